sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO: the general-depth successor to the two-entry tiny FIFO used on AXI4 channel skid points. Depth, width and almost-full/almost-empty thresholds are set by parameters. The block adds a registered occupancy count and sticky overflow/underflow error flags in place of simulation-only stops. It sits between AXI4 channel producers and consumers wherever more than two beats of elasticity are needed.

## Interface
- W, 8, data width in bits (>= 1)
- D, 4, depth in entries; power of two, >= 2
- AF_THRESH, D-1, wr_almost_full asserts when occupancy >= AF_THRESH (1..D)
- AE_THRESH, 1, rd_almost_empty asserts when occupancy <= AE_THRESH (0..D-1)
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high
- wr_data  input  W  write data
- wr_en  input  1  write request
- wr_full  output  1  FIFO full; a write is ignored while high
- wr_almost_full  output  1  occupancy >= AF_THRESH
- rd_data  output  W  head-of-queue data (show-ahead); valid while rd_empty is low
- rd_en  input  1  read request; pops the head
- rd_empty  output  1  FIFO empty; a read is ignored while high
- rd_almost_empty  output  1  occupancy <= AE_THRESH
- count  output  $clog2(D)+1  current occupancy, 0..D
- wr_overflow  output  1  sticky: wr_en was seen while wr_full was high
- rd_underflow  output  1  sticky: rd_en was seen while rd_empty was high

## Operation
- Accepted operations: writing = wr_en & ~wr_full; reading = rd_en & ~rd_empty. Rejected requests change no data and no pointers.
- Pointers: rd_ptr and wr_ptr are $clog2(D)+1 bits wide. The MSB is the wrap bit. Each pointer increments by 1 on an accepted operation and wraps modulo 2D.
- Next-pointer values are computed combinationally. Reset forces both next pointers to 0.
- Memory: D x W register array. An accepted write stores wr_data at wr_ptr[low bits]. rd_data = mem[rd_ptr[low bits]], driven combinationally from the registered rd_ptr.
- Flags and count are computed from the next pointers and registered. They are therefore coherent with the pointers in every cycle:
  - empty_next = (next_wr == next_rd)
  - full_next = low bits equal and MSBs differ
  - count_next = next_wr - next_rd, truncated to $clog2(D)+1 bits
  - almost_full_next = count_next >= AF_THRESH
  - almost_empty_next = count_next <= AE_THRESH
- Simultaneous read and write:
  - When neither full nor empty, both operations are accepted and count is unchanged.
  - When full, only the read is accepted; wr_overflow sets.
  - When empty, only the write is accepted; rd_underflow sets.
  - There is no write-through bypass: data written into an empty FIFO becomes visible one cycle later.
- Error flags: wr_overflow sets on any clock where wr_en & wr_full. rd_underflow sets on any clock where rd_en & rd_empty. Both hold until reset.
- Reset values:
  - rd_empty = 1, wr_full = 0
  - count = 0, wr_almost_full = 0
  - rd_almost_empty = 1
  - wr_overflow = 0, rd_underflow = 0
  - pointers = 0
  - Memory is not reset; rd_data is undefined until the first write.
- Reset asserted mid-operation discards all contents. On the clock edge where reset is sampled high, wr_en and rd_en are ignored.

## Timing
- Write-to-read latency is 1 cycle. After the edge that accepts a write to an empty FIFO, rd_empty = 0 and rd_data = written word.
- Read: rd_data advances to the next entry in the cycle after the accepting edge.
- wr_full asserts in the cycle after the write that makes occupancy D. It deasserts in the cycle after the first accepted read.
- count, wr_almost_full and rd_almost_empty all update in the same cycle as the pointers. There is no extra lag.
- Throughput: one write and one read per cycle sustained, indefinitely, through pointer wrap.
- The only combinational path from inputs to outputs is pointer to memory to rd_data; wr_en and rd_en feed only registers.

## Test plan
- Reset, then D=4, W=8: write 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - After the 4th edge: wr_full = 1, count = 4, wr_almost_full = 1.
  - Then read 4 times: rd_data = 0x11, 0x22, 0x33, 0x44 in order; rd_empty = 1 after the 4th read.
- Full FIFO, wr_en = 1 and rd_en = 1 for one cycle:
  - Only the read is accepted; count goes 4 -> 3.
  - wr_overflow = 1 and stays 1 until reset.
- Empty FIFO, rd_en = 1 and wr_en = 1 with 0xA5:
  - rd_underflow = 1.
  - Next cycle: rd_empty = 0, rd_data = 0xA5, count = 1.
- Continuous simultaneous read and write for 20 cycles from count = 2, incrementing data:
  - count stays 2.
  - Output sequence equals the input sequence delayed by 2 across several pointer wraps.
- AF_THRESH = 3, AE_THRESH = 1, fill 0 -> 4 then drain 4 -> 0:
  - wr_almost_full is 1 exactly when count >= 3.
  - rd_almost_empty is 1 exactly when count <= 1.
- Assert reset for one cycle with count = 3 and wr_en = 1:
  - Next cycle: count = 0, rd_empty = 1, wr_full = 0, error flags 0.
  - The write is discarded.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Write/read handshake bundle for sync_fifo_param.
// The producer/consumer side uses master, the FIFO uses slave.
interface sync_fifo_param_if #(
  parameter int W = 8,
  parameter int D = 4
);
  localparam int CW = $clog2(D) + 1;

  logic [W-1:0]  wr_data;
  logic          wr_en;
  logic          wr_full;
  logic          wr_almost_full;
  logic [W-1:0]  rd_data;
  logic          rd_en;
  logic          rd_empty;
  logic          rd_almost_empty;
  logic [CW-1:0] count;
  logic          wr_overflow;
  logic          rd_underflow;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, wr_almost_full, rd_data, rd_empty, rd_almost_empty,
           count, wr_overflow, rd_underflow
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, wr_almost_full, rd_data, rd_empty, rd_almost_empty,
           count, wr_overflow, rd_underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock show-ahead FIFO with registered occupancy,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int W         = 8,
  parameter int D         = 4,
  parameter int AF_THRESH = D - 1,
  parameter int AE_THRESH = 1
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(D);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [W-1:0]  r_mem [D];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW-1:0] r_count;
  logic          r_empty, r_full, r_afull, r_aempty;
  logic          r_ovf, r_udf;

  logic          w_write, w_read;
  logic [PW-1:0] w_wr_nxt, w_rd_nxt, w_cnt_nxt;

  assign w_write = bus.wr_en & ~r_full;
  assign w_read  = bus.rd_en & ~r_empty;

  // Reset folds into the next pointers so all flags derive their reset value
  // from the same equations that run in normal operation.
  always_comb begin
    w_wr_nxt = r_wr_ptr + PW'(w_write);
    w_rd_nxt = r_rd_ptr + PW'(w_read);
    if (reset) begin
      w_wr_nxt = '0;
      w_rd_nxt = '0;
    end
  end

  assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;

  always_ff @(posedge clk) begin
    r_wr_ptr <= w_wr_nxt;
    r_rd_ptr <= w_rd_nxt;
    r_count  <= w_cnt_nxt;
    r_empty  <= (w_wr_nxt == w_rd_nxt);
    r_full   <= (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) &&
                (w_wr_nxt[AW] != w_rd_nxt[AW]);
    r_afull  <= (w_cnt_nxt >= AF_T);
    r_aempty <= (w_cnt_nxt <= AE_T);
    if (reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (bus.wr_en & r_full);
      r_udf <= r_udf | (bus.rd_en & r_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (w_write && !reset) r_mem[r_wr_ptr[AW-1:0]] <= bus.wr_data;
  end

  assign bus.rd_data         = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.rd_empty        = r_empty;
  assign bus.wr_full         = r_full;
  assign bus.wr_almost_full  = r_afull;
  assign bus.rd_almost_empty = r_aempty;
  assign bus.count           = r_count;
  assign bus.wr_overflow     = r_ovf;
  assign bus.rd_underflow    = r_udf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sync_fifo_param;
  localparam int W = 8, D = 4, AF = 3, AE = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.W(W), .D(D)) bus();
  sync_fifo_param #(.W(W), .D(D), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int tests = 0, fails = 0;
  bit chk_en = 0;
  logic [W-1:0] q[$];
  bit m_ovf, m_udf, m_f, m_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated with the pre-edge full/empty state.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      m_f = (q.size() == D);
      m_e = (q.size() == 0);
      if (bus.wr_en && m_f) m_ovf = 1;
      if (bus.rd_en && m_e) m_udf = 1;
      if (bus.rd_en && !m_e) void'(q.pop_front());
      if (bus.wr_en && !m_f) q.push_back(bus.wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_empty",  bus.rd_empty,        q.size() == 0);
      chk("m_full",   bus.wr_full,         q.size() == D);
      chk("m_count",  bus.count,           q.size());
      chk("m_afull",  bus.wr_almost_full,  q.size() >= AF);
      chk("m_aempty", bus.rd_almost_empty, q.size() <= AE);
      chk("m_ovf",    bus.wr_overflow,     m_ovf);
      chk("m_udf",    bus.rd_underflow,    m_udf);
      if (q.size() > 0) chk("m_rd_data", bus.rd_data, q[0]);
    end
  end

  task automatic step(input logic we, input logic re, input logic [W-1:0] d, input logic rs);
    bus.wr_en   = we;
    bus.rd_en   = re;
    bus.wr_data = d;
    reset       = rs;
    @(negedge clk);
    #1;
  endtask

  logic [W-1:0] exp4 [4];

  initial begin
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    reset = 1'b1; bus.wr_en = 0; bus.rd_en = 0; bus.wr_data = '0;
    @(negedge clk); #1;
    step(0, 0, 0, 1);
    chk_en = 1;

    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.rd_empty, 1);
    chk("rst_full", bus.wr_full, 0);
    chk("rst_aempty", bus.rd_almost_empty, 1);
    chk("rst_afull", bus.wr_almost_full, 0);

    for (int i = 0; i < 4; i++) step(1, 0, exp4[i], 0);
    chk("fill_full", bus.wr_full, 1);
    chk("fill_count", bus.count, 4);
    chk("fill_afull", bus.wr_almost_full, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", bus.rd_data, exp4[i]);
      step(0, 1, 0, 0);
    end
    chk("drain_empty", bus.rd_empty, 1);

    for (int i = 1; i <= 4; i++) step(1, 0, 8'(i), 0);
    step(1, 1, 8'h99, 0);
    chk("ovf_count", bus.count, 3);
    chk("ovf_flag", bus.wr_overflow, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("ovf_sticky", bus.wr_overflow, 1);

    step(1, 1, 8'hA5, 0);
    chk("udf_flag", bus.rd_underflow, 1);
    chk("udf_empty", bus.rd_empty, 0);
    chk("udf_data", bus.rd_data, 8'hA5);
    chk("udf_count", bus.count, 1);

    step(1, 0, 8'h50, 0);
    for (int k = 0; k < 20; k++) begin
      chk("stream_data", bus.rd_data, (k == 0) ? 8'hA5 : (k == 1) ? 8'h50 : 8'(8'h60 + k - 2));
      step(1, 1, 8'(8'h60 + k), 0);
      chk("stream_count", bus.count, 2);
    end

    step(0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 8'(i), 0);
      chk("thr_up_af", bus.wr_almost_full, i >= 3);
      chk("thr_up_ae", bus.rd_almost_empty, i <= 1);
    end
    for (int i = 3; i >= 0; i--) begin
      step(0, 1, 0, 0);
      chk("thr_dn_af", bus.wr_almost_full, i >= 3);
      chk("thr_dn_ae", bus.rd_almost_empty, i <= 1);
    end

    step(0, 1, 0, 0);
    chk("udf2_flag", bus.rd_underflow, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hC0 + i), 0);
    chk("pre_rst_count", bus.count, 3);
    step(1, 0, 8'h77, 1);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_empty", bus.rd_empty, 1);
    chk("mid_rst_full", bus.wr_full, 0);
    chk("mid_rst_ovf", bus.wr_overflow, 0);
    chk("mid_rst_udf", bus.rd_underflow, 0);
    step(0, 0, 0, 0);
    chk("mid_rst_discard", bus.count, 0);

    for (int n = 0; n < 1500; n++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), W'($urandom),
           1'($urandom_range(99) == 0));

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
